// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bq_q, bq_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             d_bit, bn;
    logic [WIDTH-1:0] r_shift;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        count_d  = count_q;
        bq_d     = bq_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        // Single full-subtractor cell operating on the current LSBs.
        d_bit   = sa_q[0] ^ sb_q[0] ^ bq_q;
        bn      = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bq_q);
        r_shift = {d_bit, r_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bq_d    = 1'b0;
                    count_d = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                r_d     = r_shift;
                bq_d    = bn;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    diff_d   = r_shift;
                    borrow_d = bn;
                    state_d  = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // Overflow when operand signs differ and the result sign differs from a.
                    ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            count_q  <= '0;
            bq_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            count_q  <= count_d;
            bq_q     <= bq_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8), plus handshake,
// held-start and mid-operation reset sequences.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
        .overflow   (overflow),
`endif
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one subtraction and wait for done; returns latency in edges after
    // the accepting edge and the number of samples with busy high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          output int lat, output int busy_cnt, output int both);
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();               // accepting edge
        start = 1'b0;
        a = ~ta;              // operands may change freely after acceptance
        b = ~tb_v;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        both = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) both++;
        end
        if (busy && done) both++;
    endtask

    initial begin
        vec_t vecs[8];
        int lat, bcnt, both, dcount;
        logic [W-1:0] first_diff, second_diff;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        vecs[7] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow_out, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, lat, bcnt, both);
            $display("op %0d: a=0x%02h b=0x%02h diff=0x%02h borrow=%0d latency=%0d",
                     i, vecs[i].va, vecs[i].vb, diff, borrow_out, lat);
            check($sformatf("v%0d_latency", i), lat, W);
            check($sformatf("v%0d_busy_cycles", i), bcnt, W);
            check($sformatf("v%0d_busy_and_done", i), both, 0);
            check($sformatf("v%0d_diff", i), diff, vecs[i].exp_diff);
            check($sformatf("v%0d_borrow", i), borrow_out, vecs[i].exp_borrow);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].exp_ovf);
`endif
            tick();
            check($sformatf("v%0d_done_pulse_end", i), done, 0);
            check($sformatf("v%0d_diff_held", i), diff, vecs[i].exp_diff);
        end

        // Asynchronous reset mid-cycle: outputs clear with no clock edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_diff", diff, 0);
        check("async_rst_borrow", borrow_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Start held high: one done per accepted start, busy operands ignored.
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        tick();               // accepting edge E0
        a = 8'h09;
        b = 8'h01;
        dcount = 0;
        first_diff = '0;
        second_diff = '0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) check("held_prev_diff_visible", diff, 8'h00);
            tick();
            if (done) begin
                dcount++;
                if (dcount == 1) first_diff = diff;
                else second_diff = diff;
            end
        end
        start = 1'b0;
        $display("held start: dones=%0d first=0x%02h second=0x%02h", dcount, first_diff, second_diff);
        check("held_done_count", dcount, 2);
        check("held_first_diff", first_diff, 8'h02);
        check("held_second_diff", second_diff, 8'h08);

        // Reset after four shift edges: aborted, no done, diff stays cleared.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        check("midop_busy_before_rst", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midop_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int e = 0; e < 2 * W; e++) begin
            tick();
            if (done) dcount++;
        end
        $display("mid-op reset: dones=%0d diff=0x%02h", dcount, diff);
        check("midop_no_done", dcount, 0);
        check("midop_diff_zero", diff, 0);
        check("midop_borrow_zero", borrow_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
